bist_controller: RTL and testbench

//  Sequencer for the on-chip BIST datapath: TPG LFSR -> CUT -> MISR.

---
 rtl/bist_pkg.sv | 17 +
 rtl/bist_pattern_counter.sv | 28 ++
 rtl/bist_controller.sv | 148 ++++++++++++++
 tb/tb_bist_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST sequencer.
// State encoding plus default signature width and golden value.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_RUN     = 3'd2,
        S_FLUSH   = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int SIG_W_DEF = 16;
    localparam logic [SIG_W_DEF-1:0] GOLDEN_SIG_DEF = 16'hA5C3;

endpackage

// File: rtl/bist_pattern_counter.sv
// Up-counter with clear, enable and terminal-count compare.
// Shared by the RUN and FLUSH phases of the BIST sequencer.
module bist_pattern_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: TPG seed/advance, MISR clear/compact, golden compare.
// Optional BIST_SNAP_EN adds misr_snap, the signature captured at compare.
module bist_controller
    import bist_pkg::*;
#(
    parameter int              N_PATTERNS = 16,
    parameter int              CNT_W      = 8,
    parameter int              PIPE_LAT   = 1,
    parameter int              SIG_W      = SIG_W_DEF,
    parameter logic [SIG_W-1:0] GOLDEN_SIG = SIG_W'(GOLDEN_SIG_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bist_start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             bist_mode,
    output logic             tpg_load,
    output logic             tpg_en,
    output logic             misr_clear,
    output logic             misr_en,
    output logic             bist_end,
`ifdef BIST_SNAP_EN
    output logic [SIG_W-1:0] misr_snap,
`endif
    output logic             pass_nfail
);

    localparam logic [CNT_W-1:0] RUN_TERM   = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] FLUSH_TERM =
        CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic             w_tc;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic [CNT_W-1:0] w_term;

    logic r_mode, r_load, r_tpg_en, r_clear, r_misr_en, r_end, r_pass;
    logic w_mode, w_load, w_tpg_en, w_clear, w_misr_en, w_end;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bist_start) w_next = S_INIT;
            S_INIT:    w_next = S_RUN;
            S_RUN:     if (w_tc) w_next = (PIPE_LAT == 0) ? S_COMPARE : S_FLUSH;
            S_FLUSH:   if (w_tc) w_next = S_COMPARE;
            S_COMPARE: w_next = S_DONE;
            S_DONE:    if (!bist_start) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Counter restarts at 0 for RUN (cleared in INIT) and again for FLUSH.
    assign w_cnt_clr = (r_state == S_INIT) || ((r_state == S_RUN) && w_tc);
    assign w_cnt_en  = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_term    = (r_state == S_FLUSH) ? FLUSH_TERM : RUN_TERM;

    bist_pattern_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_cnt_clr),
        .i_en    (w_cnt_en),
        .i_term  (w_term),
        .o_tc    (w_tc)
    );

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        w_mode    = 1'b0;
        w_load    = 1'b0;
        w_tpg_en  = 1'b0;
        w_clear   = 1'b0;
        w_misr_en = 1'b0;
        w_end     = 1'b0;
        unique case (w_next)
            S_INIT: begin
                w_mode  = 1'b1;
                w_load  = 1'b1;
                w_clear = 1'b1;
            end
            S_RUN: begin
                w_mode    = 1'b1;
                w_tpg_en  = 1'b1;
                w_misr_en = 1'b1;
            end
            S_FLUSH: begin
                w_mode    = 1'b1;
                w_misr_en = 1'b1;
            end
            S_COMPARE: w_mode = 1'b1;
            S_DONE:    w_end  = 1'b1;
            default:   w_end  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_load    <= 1'b0;
            r_tpg_en  <= 1'b0;
            r_clear   <= 1'b0;
            r_misr_en <= 1'b0;
            r_end     <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_mode    <= w_mode;
            r_load    <= w_load;
            r_tpg_en  <= w_tpg_en;
            r_clear   <= w_clear;
            r_misr_en <= w_misr_en;
            r_end     <= w_end;
            if (r_state == S_COMPARE) begin
                r_pass <= (misr_sig == GOLDEN_SIG);
            end else if (w_next == S_INIT) begin
                r_pass <= 1'b0;
            end
        end
    end

`ifdef BIST_SNAP_EN
    logic [SIG_W-1:0] r_snap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= '0;
        end else if (r_state == S_COMPARE) begin
            r_snap <= misr_sig;
        end
    end

    assign misr_snap = r_snap;
`endif

    assign bist_mode  = r_mode;
    assign tpg_load   = r_load;
    assign tpg_en     = r_tpg_en;
    assign misr_clear = r_clear;
    assign misr_en    = r_misr_en;
    assign bist_end   = r_end;
    assign pass_nfail = r_pass;

endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller (N_PATTERNS=8, PIPE_LAT=1).
// Define BIST_SNAP_EN to also check misr_snap.
module tb_bist_controller;

    localparam int          NP   = 8;
    localparam int          PL   = 1;
    localparam logic [15:0] GOLD = 16'hA5C3;

    logic        clk = 1'b0;
    logic        reset;
    logic        bist_start;
    logic [15:0] misr_sig;
    logic        bist_mode, tpg_load, tpg_en, misr_clear, misr_en;
    logic        bist_end, pass_nfail;
`ifdef BIST_SNAP_EN
    logic [15:0] misr_snap;
`endif

    always #5 clk = ~clk;

    bist_controller #(
        .N_PATTERNS (NP),
        .CNT_W      (8),
        .PIPE_LAT   (PL),
        .SIG_W      (16),
        .GOLDEN_SIG (GOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bist_start (bist_start),
        .misr_sig   (misr_sig),
        .bist_mode  (bist_mode),
        .tpg_load   (tpg_load),
        .tpg_en     (tpg_en),
        .misr_clear (misr_clear),
        .misr_en    (misr_en),
        .bist_end   (bist_end),
`ifdef BIST_SNAP_EN
        .misr_snap  (misr_snap),
`endif
        .pass_nfail (pass_nfail)
    );

    typedef struct {
        int   t_end;
        logic pass;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   edge_n = 0;
    int   n_load = 0, n_clr = 0, n_ten = 0, n_men = 0;
    logic prev_end = 1'b0;
    int   t0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({bist_mode, tpg_load, tpg_en, misr_clear,
                    misr_en, bist_end, pass_nfail});
    endfunction

    always @(posedge clk) begin
        exp_t e;
        edge_n++;
        #1;
        if (reset) begin
            n_load = 0; n_clr = 0; n_ten = 0; n_men = 0;
            prev_end = 1'b0;
        end else begin
            if (tpg_load)   n_load++;
            if (misr_clear) n_clr++;
            if (tpg_en)     n_ten++;
            if (misr_en)    n_men++;
            if (bist_mode && !bist_end)
                chk("pnf_busy", 32'(pass_nfail), 32'(0));
            if (bist_end && !prev_end) begin
                if (q.size() == 0) begin
                    chk("unexp_end", 32'(1), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("end_edge", edge_n, e.t_end);
                    chk("pass", 32'(pass_nfail), 32'(e.pass));
                    chk("n_load", n_load, 1);
                    chk("n_clear", n_clr, 1);
                    chk("n_tpg_en", n_ten, NP);
                    chk("n_misr_en", n_men, NP + PL);
                    chk("mode_done", 32'(bist_mode), 32'(0));
                end
                n_load = 0; n_clr = 0; n_ten = 0; n_men = 0;
            end
            prev_end = bist_end;
        end
    end

    task automatic start_run(input logic [15:0] sig, input logic ep,
                             output int ts);
        @(negedge clk);
        misr_sig   = sig;
        bist_start = 1'b1;
        ts = edge_n + 1;
        q.push_back('{t_end: ts + NP + PL + 2, pass: ep});
    endtask

    task automatic wait_done();
        int k = 0;
        while (q.size() != 0 && k < 60) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (q.size() != 0) begin
            chk("timeout", 32'(q.size()), 32'(0));
            q.delete();
        end
    endtask

    task automatic stop();
        @(negedge clk);
        bist_start = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        bist_start = 1'b1;
        misr_sig   = '0;
        #100;
        chk("rst_outs", outs(), 32'(0));
        bist_start = 1'b0;
        reset      = 1'b0;
        @(posedge clk); #1;
        chk("idle_outs", outs(), 32'(0));

        start_run(GOLD, 1'b1, t0);
        wait_done();
        stop();
        @(posedge clk); #1;
        chk("end_fall", 32'(bist_end), 32'(0));
        chk("pnf_hold", 32'(pass_nfail), 32'(1));
`ifdef BIST_SNAP_EN
        chk("snap", 32'(misr_snap), 32'(GOLD));
        repeat (3) @(posedge clk);
        #1;
        chk("snap_idle", 32'(misr_snap), 32'(GOLD));
`endif

        start_run(16'hA5C2, 1'b0, t0);
        wait_done();
        stop();
        @(posedge clk); #1;
        chk("pnf_fail", 32'(pass_nfail), 32'(0));

        start_run(GOLD, 1'b1, t0);
        while (edge_n < t0 + 3) @(posedge clk);
        @(negedge clk);
        bist_start = 1'b0;
        wait_done();
        @(posedge clk); #1;
        chk("drop_fall", 32'(bist_end), 32'(0));

        start_run(GOLD, 1'b1, t0);
        repeat (40) @(posedge clk);
        #2;
        chk("hold_one", 32'(q.size()), 32'(0));
        chk("hold_end", 32'(bist_end), 32'(1));
        @(negedge clk);
        bist_start = 1'b0;
        start_run(GOLD, 1'b1, t0);
        wait_done();
        stop();

        start_run(GOLD, 1'b1, t0);
        while (edge_n < t0 + 5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid", outs(), 32'(0));
        q.delete();
        bist_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_idle", outs(), 32'(0));
        start_run(GOLD, 1'b1, t0);
        wait_done();
        stop();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
